// File: rtl/kamacore_stage_mem.sv
// kamacore_stage_mem: memory-access stage between execute and writeback.
// Issues one load/store at a time over a req/ack data-memory port, stalls
// upstream while the access is open, and produces MEM/WB with the final
// result already selected (formatted load data or ALU result).
// Optional feature macro: KAMACORE_MEM_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses skip memory and are flagged
//               on wb_misaligned
//   undefined - no wb_misaligned port; half/word lanes ignore low address bits
//
// state  | meaning
// IDLE   | accept EX/MEM; launch a memory request or pass the instruction on
// ACCESS | request open; hold dmem_* stable until dmem_ack
module kamacore_stage_mem #(
    parameter int CPU_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_valid,
    input  logic [31:0]          ex_instruction,
    input  logic [CPU_WIDTH-1:0] ex_alu_result,
    input  logic [CPU_WIDTH-1:0] ex_rs2_data,
    input  logic                 ex_rd_we,
    input  logic                 ex_mem_re,
    input  logic                 ex_mem_we,
    output logic                 mem_stall,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [CPU_WIDTH-1:0] dmem_addr,
    output logic [3:0]           dmem_be,
    output logic [CPU_WIDTH-1:0] dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [CPU_WIDTH-1:0] dmem_rdata,
    output logic                 wb_valid,
    output logic [31:0]          wb_instruction,
    output logic [CPU_WIDTH-1:0] wb_result,
`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
    output logic                 wb_misaligned,
`endif
    output logic                 wb_rd_we
);

    // Only the 32-bit datapath with 5-bit register addresses is implemented.
    if (CPU_WIDTH != 32 || REG_ADDR_WIDTH != 5) begin : g_unsupported_width
    end

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t               state_q;
    logic                 dmem_we_q;
    logic [CPU_WIDTH-1:0] dmem_addr_q;
    logic [3:0]           dmem_be_q;
    logic [CPU_WIDTH-1:0] dmem_wdata_q;
    logic [1:0]           addr_lo_q;
    logic                 wb_valid_q;
    logic                 wb_rd_we_q;
    logic [31:0]          wb_instruction_q;
    logic [CPU_WIDTH-1:0] wb_result_q;
    logic                 misaligned_q;

    logic [2:0]           funct3;
    logic [1:0]           addr_lo;
    logic                 mem_op;
    logic                 misaligned;
    logic [3:0]           be_d;
    logic [CPU_WIDTH-1:0] wdata_d;
    logic [7:0]           load_byte;
    logic [15:0]          load_half;
    logic [CPU_WIDTH-1:0] load_data;

    assign funct3  = ex_instruction[14:12];
    assign addr_lo = ex_alu_result[1:0];
    assign mem_op  = ex_valid & (ex_mem_re | ex_mem_we);

`ifdef KAMACORE_MEM_MISALIGN_TRAP_EN
    assign misaligned = ((funct3[1:0] == 2'b01) & addr_lo[0]) |
                        ((funct3[1:0] == 2'b10) & (addr_lo != 2'b00));
    assign wb_misaligned = misaligned_q;
`else
    assign misaligned = 1'b0;
`endif

    // Byte enables and lane-replicated store data for the request being launched
    always_comb begin
        be_d    = 4'b1111;
        wdata_d = ex_rs2_data;
        if (ex_mem_we) begin
            case (funct3[1:0])
                2'b00: begin
                    be_d    = 4'b0001 << addr_lo;
                    wdata_d = {4{ex_rs2_data[7:0]}};
                end
                2'b01: begin
                    be_d    = 4'b0011 << {addr_lo[1], 1'b0};
                    wdata_d = {2{ex_rs2_data[15:0]}};
                end
                default: begin
                    be_d    = 4'b1111;
                    wdata_d = ex_rs2_data;
                end
            endcase
        end
    end

    // Load lane select and extension, driven by the address latched at launch
    always_comb begin
        case (addr_lo_q)
            2'b00:   load_byte = dmem_rdata[7:0];
            2'b01:   load_byte = dmem_rdata[15:8];
            2'b10:   load_byte = dmem_rdata[23:16];
            default: load_byte = dmem_rdata[31:24];
        endcase
        load_half = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3)
            3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
            3'b100:  load_data = {24'd0, load_byte};
            3'b001:  load_data = {{16{load_half[15]}}, load_half};
            3'b101:  load_data = {16'd0, load_half};
            default: load_data = dmem_rdata;
        endcase
    end

    // Stall: launching cycle always stalls; an open access stalls until ack
    always_comb begin
        mem_stall = 1'b0;
        if (state_q == S_ACCESS) begin
            mem_stall = !dmem_ack;
        end else begin
            mem_stall = mem_op & !misaligned;
        end
    end

    // Stage FSM, request registers and MEM/WB register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_be_q        <= 4'b0000;
            dmem_wdata_q     <= '0;
            addr_lo_q        <= 2'b00;
            wb_valid_q       <= 1'b0;
            wb_rd_we_q       <= 1'b0;
            wb_instruction_q <= '0;
            wb_result_q      <= '0;
            misaligned_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_op && !misaligned) begin
                        state_q      <= S_ACCESS;
                        dmem_we_q    <= ex_mem_we;
                        dmem_addr_q  <= {ex_alu_result[CPU_WIDTH-1:2], 2'b00};
                        dmem_be_q    <= be_d;
                        dmem_wdata_q <= wdata_d;
                        addr_lo_q    <= addr_lo;
                        wb_valid_q   <= 1'b0;
                        wb_rd_we_q   <= 1'b0;
                        misaligned_q <= 1'b0;
                    end else if (mem_op) begin
                        // Trapped access: retire with the flag, never touch memory
                        wb_valid_q       <= 1'b1;
                        wb_rd_we_q       <= 1'b0;
                        wb_instruction_q <= ex_instruction;
                        wb_result_q      <= ex_alu_result;
                        misaligned_q     <= 1'b1;
                    end else begin
                        wb_valid_q       <= ex_valid;
                        wb_rd_we_q       <= ex_valid & ex_rd_we;
                        wb_instruction_q <= ex_instruction;
                        wb_result_q      <= ex_alu_result;
                        misaligned_q     <= 1'b0;
                    end
                end
                default: begin
                    if (dmem_ack) begin
                        state_q          <= S_IDLE;
                        wb_valid_q       <= ex_valid;
                        wb_rd_we_q       <= ex_valid & ex_rd_we;
                        wb_instruction_q <= ex_instruction;
                        wb_result_q      <= ex_mem_re ? load_data : ex_alu_result;
                    end else begin
                        wb_valid_q <= 1'b0;
                        wb_rd_we_q <= 1'b0;
                    end
                    misaligned_q <= 1'b0;
                end
            endcase
        end
    end

    assign dmem_req       = (state_q == S_ACCESS);
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_be        = dmem_be_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd_we       = wb_rd_we_q;
    assign wb_instruction = wb_instruction_q;
    assign wb_result      = wb_result_q;

endmodule
